// File: rtl/xillybus_mem8_regs.sv
// xillybus_mem8_regs: user-side responder for the Xillybus seekable
// 8-bit stream, exposing scratch RAM and a small register file.
module xillybus_mem8_regs #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] CTRL_RESET = 8'h00
) (
    input  logic       bus_clk,
    input  logic       trn_reset_n,
    input  logic       user_w_mem_8_wren,
    input  logic [7:0] user_w_mem_8_data,
    output logic       user_w_mem_8_full,
    input  logic       user_w_mem_8_open,
    input  logic       user_r_mem_8_rden,
    output logic [7:0] user_r_mem_8_data,
    output logic       user_r_mem_8_empty,
    output logic       user_r_mem_8_eof,
    input  logic       user_r_mem_8_open,
    input  logic [4:0] user_mem_8_addr,
    input  logic       user_mem_8_addr_update,
    output logic [7:0] ctrl_out,
    input  logic [7:0] status_in,
    input  logic [7:0] event_in,
    output logic       irq_out
);

    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [4:0] A_STAT = 5'h11;
    localparam logic [4:0] A_IRQ  = 5'h12;
    localparam logic [4:0] A_WRC  = 5'h13;
    localparam logic [4:0] A_RDC  = 5'h14;
    localparam logic [4:0] A_ID   = 5'h1F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD1 = 2'd1,
        S_HOLD2 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_hold;

    logic [7:0] r_scratch [16];
    logic [7:0] r_ctrl;
    logic [7:0] r_status_q;
    logic [7:0] r_irq_pend;
    logic       r_irq;
    logic [7:0] r_wr_count;
    logic [7:0] r_rd_count;
    logic [7:0] r_rd_data;
    logic       r_w_open_q;
    logic       r_r_open_q;

    logic       w_wr_acc;
    logic       w_rd_acc;
    logic       w_wr_scr;
    logic       w_wr_ctrl;
    logic [7:0] w_irq_clr;
    logic [7:0] w_rd_byte;
    logic       w_w_open_rise;
    logic       w_r_open_rise;

    assign w_hold             = (r_state != S_IDLE);
    assign user_w_mem_8_full  = w_hold;
    assign user_r_mem_8_empty = w_hold;
    assign user_r_mem_8_eof   = 1'b0;
    assign user_r_mem_8_data  = r_rd_data;
    assign ctrl_out           = r_ctrl;
    assign irq_out            = r_irq;

    assign w_wr_acc = user_w_mem_8_wren & ~w_hold;
    assign w_rd_acc = user_r_mem_8_rden & ~w_hold;

    assign w_wr_scr  = w_wr_acc & ~user_mem_8_addr[4];
    assign w_wr_ctrl = w_wr_acc & (user_mem_8_addr == A_CTRL);
    assign w_irq_clr = (w_wr_acc && (user_mem_8_addr == A_IRQ))
                       ? user_w_mem_8_data : 8'h00;

    assign w_w_open_rise = user_w_mem_8_open & ~r_w_open_q;
    assign w_r_open_rise = user_r_mem_8_open & ~r_r_open_q;

    // Seek-hold state register.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // Seek-hold next state: a seek pulse always (re)starts the hold.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (user_mem_8_addr_update) begin
            w_state_nxt = S_HOLD1;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_HOLD1: w_state_nxt = S_HOLD2;
                S_HOLD2: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Scratch RAM, intentionally left unreset.
    always_ff @(posedge bus_clk) begin
        if (w_wr_scr) r_scratch[user_mem_8_addr[3:0]] <= user_w_mem_8_data;
    end

    // Read mux over the full 32-byte map; reserved bytes read as zero.
    always_comb begin
        w_rd_byte = 8'h00;
        if (!user_mem_8_addr[4]) begin
            w_rd_byte = r_scratch[user_mem_8_addr[3:0]];
        end else begin
            case (user_mem_8_addr)
                A_CTRL:  w_rd_byte = r_ctrl;
                A_STAT:  w_rd_byte = r_status_q;
                A_IRQ:   w_rd_byte = r_irq_pend;
                A_WRC:   w_rd_byte = r_wr_count;
                A_RDC:   w_rd_byte = r_rd_count;
                A_ID:    w_rd_byte = ID_VALUE;
                default: w_rd_byte = 8'h00;
            endcase
        end
    end

    // Read data register, holds until the next accepted read.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n)  r_rd_data <= 8'h00;
        else if (w_rd_acc) r_rd_data <= w_rd_byte;
    end

    // Control register.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n)   r_ctrl <= CTRL_RESET;
        else if (w_wr_ctrl) r_ctrl <= user_w_mem_8_data;
    end

    // Status snapshot, sampled every cycle.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) r_status_q <= 8'h00;
        else              r_status_q <= status_in;
    end

    // Pending events: new events win over a same-cycle clear.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_irq_pend <= 8'h00;
            r_irq      <= 1'b0;
        end else begin
            r_irq_pend <= (r_irq_pend & ~w_irq_clr) | event_in;
            r_irq      <= |r_irq_pend;
        end
    end

    // Previous values of the open handles for rising-edge detection.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_w_open_q <= 1'b0;
            r_r_open_q <= 1'b0;
        end else begin
            r_w_open_q <= user_w_mem_8_open;
            r_r_open_q <= user_r_mem_8_open;
        end
    end

    // Write access counter; a new open clears it ahead of counting.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n)       r_wr_count <= 8'h00;
        else if (w_w_open_rise) r_wr_count <= 8'h00;
        else if (w_wr_acc)      r_wr_count <= r_wr_count + 8'd1;
    end

    // Read access counter; a new open clears it ahead of counting.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n)       r_rd_count <= 8'h00;
        else if (w_r_open_rise) r_rd_count <= 8'h00;
        else if (w_rd_acc)      r_rd_count <= r_rd_count + 8'd1;
    end

endmodule
